// File: rtl/wts_pkg.sv
// Shared wave-table SRAM definitions: default sizes, id encoding and read tags.
package wts_pkg;

    localparam int unsigned NCH_DEFAULT = 12;
    localparam int unsigned AW_DEFAULT  = 7;
    localparam int unsigned CHW         = 4;   // channel index and memory id width
    localparam int unsigned LW          = CHW - 1;
    localparam int unsigned DW          = 8;
    localparam int unsigned CH_PER_BANK = 6;

    // Tag that follows an SRAM read down the pipe to its return slot
    typedef struct packed {
        logic           ch_rd;
        logic           cpu_rd;
        logic [CHW-1:0] ch;
    } rd_tag_t;

    // Channel index -> {bank, letter} memory id
    function automatic logic [CHW-1:0] ch_to_id(input logic [CHW-1:0] ch);
        logic          bank;
        logic [LW-1:0] letter;
        bank   = (32'(ch) >= CH_PER_BANK);
        letter = bank ? LW'(32'(ch) - CH_PER_BANK) : LW'(ch);
        return {bank, letter};
    endfunction

endpackage

// File: rtl/wts_rr_picker.sv
// Combinational round-robin search: first set request at or after ptr, wrapping.
module wts_rr_picker #(
    parameter int unsigned N  = 12,
    parameter int unsigned IW = 4
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    localparam int unsigned SW = IW + 1;

    // Scan N candidates starting at ptr, modulo N
    always_comb begin
        logic [SW-1:0] sum;
        logic [IW-1:0] cand;
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        cand  = '0;
        for (int unsigned off = 0; off < N; off++) begin
            sum = {1'b0, ptr} + SW'(off);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            cand = sum[IW-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/wts_sram_arbiter.sv
// Single-port wave SRAM arbiter: CPU first (no back-to-back wins under channel load),
// channels round-robin, reads returned two cycles after the grant.
module wts_sram_arbiter
    import wts_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEFAULT,
    parameter int unsigned AW  = AW_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH*AW-1:0] ch_addr,
    output logic [NCH-1:0]    ch_ack,
    output logic              fetch_valid,
    output logic [CHW-1:0]    fetch_ch,
    output logic [DW-1:0]     fetch_data,
    input  logic              cpu_wrreq,
    input  logic              cpu_rdreq,
    input  logic [CHW-1:0]    cpu_id,
    input  logic [AW-1:0]     cpu_a,
    input  logic [DW-1:0]     cpu_d,
    output logic              cpu_ack,
    output logic [DW-1:0]     cpu_q,
    output logic              cpu_q_en,
    output logic [CHW-1:0]    sram_id,
    output logic [AW-1:0]     sram_a,
    output logic [DW-1:0]     sram_d,
    output logic              sram_oe,
    output logic              sram_we,
    input  logic [DW-1:0]     sram_q
);

    logic [CHW-1:0] rr_ptr_q, rr_ptr_d;
    logic           cpu_last_q, cpu_last_d;
    logic           sram_oe_q, sram_oe_d, sram_we_q, sram_we_d;
    logic [CHW-1:0] sram_id_q, sram_id_d;
    logic [AW-1:0]  sram_a_q, sram_a_d;
    logic [DW-1:0]  sram_d_q, sram_d_d;
    rd_tag_t        tag1_q, tag1_d;
    logic           fetch_valid_q, fetch_valid_d, cpu_q_en_q, cpu_q_en_d;
    logic [CHW-1:0] fetch_ch_q, fetch_ch_d;
    logic [DW-1:0]  fetch_hold_q, fetch_hold_d, cpu_hold_q, cpu_hold_d;

    logic           ch_found, cpu_win, ch_win;
    logic [CHW-1:0] pick;
    logic [AW-1:0]  ch_addr_a [NCH];

    // Unpack the per-channel address bus
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            ch_addr_a[i] = ch_addr[i*AW +: AW];
        end
    end

    wts_rr_picker #(
        .N  (NCH),
        .IW (CHW)
    ) u_picker (
        .req   (ch_req),
        .ptr   (rr_ptr_q),
        .found (ch_found),
        .idx   (pick)
    );

    // Grant decision; nothing is granted while reset is held
    always_comb begin
        cpu_win = 1'b0;
        ch_win  = 1'b0;
        if (!reset) begin
            cpu_win = (cpu_wrreq || cpu_rdreq) && !(cpu_last_q && (|ch_req));
            ch_win  = !cpu_win && ch_found;
        end
    end

    assign cpu_ack = cpu_win;
    assign ch_ack  = ch_win ? (NCH'(1) << pick) : '0;

    // Next state: SRAM command for this grant and read-return pipeline
    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        cpu_last_d    = 1'b0;
        sram_oe_d     = 1'b0;
        sram_we_d     = 1'b0;
        sram_id_d     = sram_id_q;
        sram_a_d      = sram_a_q;
        sram_d_d      = sram_d_q;
        tag1_d        = '0;
        fetch_valid_d = tag1_q.ch_rd;
        fetch_ch_d    = tag1_q.ch_rd ? tag1_q.ch : fetch_ch_q;
        cpu_q_en_d    = tag1_q.cpu_rd;
        fetch_hold_d  = fetch_valid_q ? sram_q : fetch_hold_q;
        cpu_hold_d    = cpu_q_en_q ? sram_q : cpu_hold_q;
        if (cpu_win) begin
            cpu_last_d = 1'b1;
            sram_id_d  = cpu_id;
            sram_a_d   = cpu_a;
            if (cpu_wrreq) begin
                sram_we_d = 1'b1;
                sram_d_d  = cpu_d;
            end else begin
                sram_oe_d     = 1'b1;
                tag1_d.cpu_rd = 1'b1;
            end
        end else if (ch_win) begin
            rr_ptr_d     = (pick == CHW'(NCH - 1)) ? '0 : pick + CHW'(1);
            sram_id_d    = ch_to_id(pick);
            sram_a_d     = ch_addr_a[pick];
            sram_oe_d    = 1'b1;
            tag1_d.ch_rd = 1'b1;
            tag1_d.ch    = pick;
        end
    end

    // State registers with synchronous reset; in-flight read tags are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q      <= '0;
            cpu_last_q    <= 1'b0;
            sram_oe_q     <= 1'b0;
            sram_we_q     <= 1'b0;
            sram_id_q     <= '0;
            sram_a_q      <= '0;
            sram_d_q      <= '0;
            tag1_q        <= '0;
            fetch_valid_q <= 1'b0;
            fetch_ch_q    <= '0;
            cpu_q_en_q    <= 1'b0;
            fetch_hold_q  <= '0;
            cpu_hold_q    <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            cpu_last_q    <= cpu_last_d;
            sram_oe_q     <= sram_oe_d;
            sram_we_q     <= sram_we_d;
            sram_id_q     <= sram_id_d;
            sram_a_q      <= sram_a_d;
            sram_d_q      <= sram_d_d;
            tag1_q        <= tag1_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_ch_q    <= fetch_ch_d;
            cpu_q_en_q    <= cpu_q_en_d;
            fetch_hold_q  <= fetch_hold_d;
            cpu_hold_q    <= cpu_hold_d;
        end
    end

    assign sram_oe     = sram_oe_q;
    assign sram_we     = sram_we_q;
    assign sram_id     = sram_id_q;
    assign sram_a      = sram_a_q;
    assign sram_d      = sram_d_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_ch    = fetch_ch_q;
    assign cpu_q_en    = cpu_q_en_q;
    // sram_q lands in the return slot itself; otherwise the last sample is held
    assign fetch_data  = fetch_valid_q ? sram_q : fetch_hold_q;
    assign cpu_q       = cpu_q_en_q ? sram_q : cpu_hold_q;

endmodule

// File: tb/tb_wts_sram_arbiter.sv
// Bench for wts_sram_arbiter: directed vectors, corner sequences, random vs. reference model.
module tb_wts_sram_arbiter;

    localparam int NCH = 12;
    localparam int AW  = 7;
    localparam int NA  = 1 << AW;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    ch_req;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH-1:0]    ch_ack;
    logic              fetch_valid;
    logic [3:0]        fetch_ch;
    logic [7:0]        fetch_data;
    logic              cpu_wrreq, cpu_rdreq;
    logic [3:0]        cpu_id;
    logic [AW-1:0]     cpu_a;
    logic [7:0]        cpu_d;
    logic              cpu_ack;
    logic [7:0]        cpu_q;
    logic              cpu_q_en;
    logic [3:0]        sram_id;
    logic [AW-1:0]     sram_a;
    logic [7:0]        sram_d;
    logic              sram_oe, sram_we;
    logic [7:0]        sram_q;

    logic [AW-1:0]     addr_tb [NCH];
    logic              tb_clr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NCH; i++) ch_addr[i*AW +: AW] = addr_tb[i];
    end

    wts_sram_arbiter #(.NCH(NCH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .ch_req(ch_req), .ch_addr(ch_addr), .ch_ack(ch_ack),
        .fetch_valid(fetch_valid), .fetch_ch(fetch_ch), .fetch_data(fetch_data),
        .cpu_wrreq(cpu_wrreq), .cpu_rdreq(cpu_rdreq), .cpu_id(cpu_id), .cpu_a(cpu_a),
        .cpu_d(cpu_d), .cpu_ack(cpu_ack), .cpu_q(cpu_q), .cpu_q_en(cpu_q_en),
        .sram_id(sram_id), .sram_a(sram_a), .sram_d(sram_d), .sram_oe(sram_oe),
        .sram_we(sram_we), .sram_q(sram_q)
    );

    // Behavioural SRAM: unwritten cells read a fixed pattern; read data one cycle after oe
    function automatic logic [7:0] init_val(input int id, input int a);
        return 8'(id * 37 + a * 5 + 90);
    endfunction

    logic [7:0] mem  [16][NA];
    logic       memw [16][NA];

    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < NA; j++) memw[i][j] <= 1'b0;
            sram_q <= 8'h00;
        end else begin
            if (sram_we) begin
                mem[sram_id][sram_a]  <= sram_d;
                memw[sram_id][sram_a] <= 1'b1;
            end
            if (sram_oe)
                sram_q <= memw[sram_id][sram_a] ? mem[sram_id][sram_a]
                                                : init_val(int'(sram_id), int'(sram_a));
        end
    end

    // Reference memory contents as the bench expects them
    logic [7:0] ref_mem [16][NA];
    logic       ref_w   [16][NA];

    function automatic logic [7:0] ref_read(input int id, input int a);
        return ref_w[id][a] ? ref_mem[id][a] : init_val(id, a);
    endfunction

    task automatic ref_write(input int id, input int a, input logic [7:0] d);
        ref_mem[id][a] = d;
        ref_w[id][a]   = 1'b1;
    endtask

    function automatic logic [3:0] exp_id(input int c);
        return 4'((c / 6) * 8 + c % 6);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ch_req = '0; cpu_wrreq = 1'b0; cpu_rdreq = 1'b0;
        cpu_id = '0; cpu_a = '0; cpu_d = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " ch_ack"}, int'(ch_ack), 0);
        chk({tag, " cpu_ack"}, int'(cpu_ack), 0);
        chk({tag, " fetch_valid"}, int'(fetch_valid), 0);
        chk({tag, " fetch_ch"}, int'(fetch_ch), 0);
        chk({tag, " fetch_data"}, int'(fetch_data), 0);
        chk({tag, " cpu_q"}, int'(cpu_q), 0);
        chk({tag, " cpu_q_en"}, int'(cpu_q_en), 0);
        chk({tag, " sram_id"}, int'(sram_id), 0);
        chk({tag, " sram_a"}, int'(sram_a), 0);
        chk({tag, " sram_d"}, int'(sram_d), 0);
        chk({tag, " sram_oe"}, int'(sram_oe), 0);
        chk({tag, " sram_we"}, int'(sram_we), 0);
    endtask

    // Reset with requests asserted so that ack gating during reset is exercised
    task automatic do_reset(input bit check);
        reset = 1'b1; tb_clr = 1'b1;
        ch_req = '1; cpu_wrreq = 1'b1; cpu_rdreq = 1'b0;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < NA; j++) ref_w[i][j] = 1'b0;
        tick(); tick();
        sample();
        if (check) check_all_zero("in_reset");
        tick();
        reset = 1'b0; tb_clr = 1'b0;
        clear_inputs();
    endtask

    typedef struct {
        logic [NCH-1:0] req;
        logic           wr, rd;
        logic [NCH-1:0] e_ack;
        logic           e_cpu, e_oe, e_we;
        logic [3:0]     e_id;
        logic [AW-1:0]  e_a;
    } vec_t;

    typedef struct {
        int            kind;    // 0 none, 1 channel read, 2 cpu write, 3 cpu read
        int            ch;
        logic [3:0]    id;
        logic [AW-1:0] a;
        logic [7:0]    d;
    } op_t;

    initial begin
        vec_t vecs [10];
        int   seq [5];
        logic [NCH-1:0] pend;
        bit   cwr, crd, cpu_last;
        int   last_ch;
        op_t  p1, p2, cur;
        logic [7:0] exp_fd, exp_cq;
        logic [NCH-1:0] eack;

        clear_inputs();
        for (int i = 0; i < NCH; i++) addr_tb[i] = AW'(i * 9 + 3);

        vecs[0] = '{12'h000, 0, 0, 12'h000, 0, 0, 0, 4'h0, 7'd0};
        vecs[1] = '{12'h200, 0, 0, 12'h200, 0, 1, 0, 4'hB, 7'd84};
        vecs[2] = '{12'h801, 0, 0, 12'h001, 0, 1, 0, 4'h0, 7'd3};
        vecs[3] = '{12'h800, 0, 0, 12'h800, 0, 1, 0, 4'hD, 7'd102};
        vecs[4] = '{12'h040, 0, 0, 12'h040, 0, 1, 0, 4'h8, 7'd57};
        vecs[5] = '{12'h005, 1, 0, 12'h000, 1, 0, 1, 4'hA, 7'h33};
        vecs[6] = '{12'h000, 0, 1, 12'h000, 1, 1, 0, 4'hA, 7'h33};
        vecs[7] = '{12'h000, 1, 1, 12'h000, 1, 0, 1, 4'hA, 7'h33};
        vecs[8] = '{12'h020, 0, 0, 12'h020, 0, 1, 0, 4'h5, 7'd48};
        vecs[9] = '{12'hFFF, 0, 1, 12'h000, 1, 1, 0, 4'hA, 7'h33};

        do_reset(1'b1);

        // Single-grant vectors, each from a fresh reset
        for (int v = 0; v < 10; v++) begin
            do_reset(1'b0);
            ch_req = vecs[v].req; cpu_wrreq = vecs[v].wr; cpu_rdreq = vecs[v].rd;
            cpu_id = 4'hA; cpu_a = 7'h33; cpu_d = 8'h77;
            sample();
            chk($sformatf("vec%0d ch_ack", v), int'(ch_ack), int'(vecs[v].e_ack));
            chk($sformatf("vec%0d cpu_ack", v), int'(cpu_ack), int'(vecs[v].e_cpu));
            tick();
            clear_inputs();
            sample();
            chk($sformatf("vec%0d sram_oe", v), int'(sram_oe), int'(vecs[v].e_oe));
            chk($sformatf("vec%0d sram_we", v), int'(sram_we), int'(vecs[v].e_we));
            if (vecs[v].e_oe || vecs[v].e_we) begin
                chk($sformatf("vec%0d sram_id", v), int'(sram_id), int'(vecs[v].e_id));
                chk($sformatf("vec%0d sram_a", v), int'(sram_a), int'(vecs[v].e_a));
            end
            if (vecs[v].e_we) chk($sformatf("vec%0d sram_d", v), int'(sram_d), 8'h77);
            tick();
        end

        // All channels requesting: strict rotation from channel 0, data two cycles later
        do_reset(1'b0);
        for (int k = 0; k < 15; k++) begin
            ch_req = (k <= 12) ? '1 : '0;
            sample();
            chk($sformatf("rot ack k%0d", k), int'(ch_ack), (k <= 12) ? (1 << (k % NCH)) : 0);
            chk($sformatf("rot sram_oe k%0d", k), int'(sram_oe), (k >= 1 && k <= 13) ? 1 : 0);
            if (k >= 2) begin
                chk($sformatf("rot fetch_valid k%0d", k), int'(fetch_valid), 1);
                chk($sformatf("rot fetch_ch k%0d", k), int'(fetch_ch), (k - 2) % NCH);
                chk($sformatf("rot fetch_data k%0d", k), int'(fetch_data),
                    int'(ref_read(int'(exp_id((k - 2) % NCH)), int'(addr_tb[(k - 2) % NCH]))));
            end
            tick();
        end

        // CPU held against two channels: cpu, ch0, cpu, ch1, cpu
        do_reset(1'b0);
        seq = '{-1, 0, -1, 1, -1};
        pend = 12'h003;
        cpu_id = 4'h2; cpu_a = 7'h11; cpu_d = 8'h5C;
        for (int k = 0; k < 6; k++) begin
            cpu_wrreq = (k < 5); ch_req = pend;
            sample();
            chk($sformatf("starve cpu_ack k%0d", k), int'(cpu_ack), (k < 5 && seq[k] < 0) ? 1 : 0);
            chk($sformatf("starve ch_ack k%0d", k), int'(ch_ack), (k < 5 && seq[k] >= 0) ? (1 << seq[k]) : 0);
            if (k >= 1) begin
                chk($sformatf("starve sram_we k%0d", k), int'(sram_we), (seq[k-1] < 0) ? 1 : 0);
                chk($sformatf("starve sram_oe k%0d", k), int'(sram_oe), (seq[k-1] >= 0) ? 1 : 0);
            end
            if (k < 5 && seq[k] >= 0) pend[seq[k]] = 1'b0;
            if (k < 5 && seq[k] < 0) ref_write(2, 7'h11, 8'h5C);
            tick();
        end

        // Simultaneous write and read: write first, read next, cpu_q two cycles after its grant
        do_reset(1'b0);
        cpu_id = 4'h9; cpu_a = 7'h2A; cpu_d = 8'hC3; cpu_wrreq = 1'b1; cpu_rdreq = 1'b1;
        sample(); chk("wr_rd grant0 cpu_ack", int'(cpu_ack), 1);
        tick(); cpu_wrreq = 1'b0;
        sample(); chk("wr_rd grant1 cpu_ack", int'(cpu_ack), 1);
        chk("wr_rd sram_we", int'(sram_we), 1); chk("wr_rd sram_d", int'(sram_d), 8'hC3);
        tick(); cpu_rdreq = 1'b0;
        sample(); chk("wr_rd sram_oe", int'(sram_oe), 1); chk("wr_rd no_we", int'(sram_we), 0);
        chk("wr_rd idle ack", int'(cpu_ack), 0);
        tick();
        sample(); chk("wr_rd cpu_q_en", int'(cpu_q_en), 1); chk("wr_rd cpu_q", int'(cpu_q), 8'hC3);
        tick();
        sample(); chk("wr_rd q_en low", int'(cpu_q_en), 0); chk("wr_rd cpu_q hold", int'(cpu_q), 8'hC3);
        tick();

        // Channel 9 fetch
        do_reset(1'b0);
        addr_tb[9] = 7'h15; ch_req = 12'h200;
        sample(); chk("ch9 ack", int'(ch_ack), 12'h200);
        tick(); ch_req = '0;
        sample(); chk("ch9 sram_id", int'(sram_id), 4'b1011); chk("ch9 sram_a", int'(sram_a), 7'h15);
        chk("ch9 sram_oe", int'(sram_oe), 1);
        tick();
        sample(); chk("ch9 fetch_valid", int'(fetch_valid), 1); chk("ch9 fetch_ch", int'(fetch_ch), 9);
        chk("ch9 fetch_data", int'(fetch_data), int'(ref_read(11, 7'h15)));
        tick();

        // Reset one cycle after a grant discards the read
        do_reset(1'b0);
        ch_req = 12'h004;
        sample(); chk("midrst ack", int'(ch_ack), 12'h004);
        tick(); ch_req = '0; reset = 1'b1;
        sample();
        tick(); reset = 1'b0;
        sample(); check_all_zero("midrst after");
        tick();
        sample(); chk("midrst fetch_valid+1", int'(fetch_valid), 0);
        tick();
        sample(); chk("midrst fetch_valid+2", int'(fetch_valid), 0);
        tick();

        // Idle
        for (int k = 0; k < 20; k++) begin
            sample();
            chk($sformatf("idle oe k%0d", k), int'(sram_oe), 0);
            chk($sformatf("idle we k%0d", k), int'(sram_we), 0);
            chk($sformatf("idle ack k%0d", k), int'({ch_ack, cpu_ack}), 0);
            tick();
        end

        // Random traffic against the reference model
        do_reset(1'b0);
        pend = '0; cwr = 0; crd = 0; cpu_last = 0; last_ch = NCH - 1;
        p1 = '{0, 0, 4'h0, 7'd0, 8'h00}; p2 = p1;
        exp_fd = 8'h00; exp_cq = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NCH; c++)
                if (!pend[c] && ($urandom % 4) == 0) begin
                    pend[c] = 1'b1; addr_tb[c] = AW'($urandom);
                end
            if (!cwr && !crd && ($urandom % 3) == 0) begin
                int r;
                r = int'($urandom % 3);
                cwr = (r != 1); crd = (r != 0);
                cpu_id = 4'(($urandom % 2) * 8 + $urandom % 6);
                cpu_a = AW'($urandom); cpu_d = 8'($urandom);
            end
            ch_req = pend; cpu_wrreq = cwr; cpu_rdreq = crd;
            sample();

            cur = '{0, 0, 4'h0, 7'd0, 8'h00};
            eack = '0;
            if ((cwr || crd) && !(cpu_last && pend != 0)) begin
                cur.kind = cwr ? 2 : 3;
                cur.id = cpu_id; cur.a = cpu_a; cur.d = cpu_d;
            end else if (pend != 0) begin
                for (int off = 1; off <= NCH; off++) begin
                    int c;
                    c = (last_ch + off) % NCH;
                    if (cur.kind == 0 && pend[c]) begin
                        cur.kind = 1; cur.ch = c; cur.id = exp_id(c); cur.a = addr_tb[c];
                        eack = NCH'(1) << c;
                    end
                end
            end

            chk("rnd ch_ack", int'(ch_ack), int'(eack));
            chk("rnd cpu_ack", int'(cpu_ack), (cur.kind >= 2) ? 1 : 0);
            chk("rnd sram_oe", int'(sram_oe), (p1.kind == 1 || p1.kind == 3) ? 1 : 0);
            chk("rnd sram_we", int'(sram_we), (p1.kind == 2) ? 1 : 0);
            if (p1.kind != 0) begin
                chk("rnd sram_id", int'(sram_id), int'(p1.id));
                chk("rnd sram_a", int'(sram_a), int'(p1.a));
            end
            if (p1.kind == 2) chk("rnd sram_d", int'(sram_d), int'(p1.d));
            if (p2.kind == 1) exp_fd = p2.d;
            if (p2.kind == 3) exp_cq = p2.d;
            chk("rnd fetch_valid", int'(fetch_valid), (p2.kind == 1) ? 1 : 0);
            if (p2.kind == 1) chk("rnd fetch_ch", int'(fetch_ch), p2.ch);
            chk("rnd fetch_data", int'(fetch_data), int'(exp_fd));
            chk("rnd cpu_q_en", int'(cpu_q_en), (p2.kind == 3) ? 1 : 0);
            chk("rnd cpu_q", int'(cpu_q), int'(exp_cq));

            if (cur.kind == 2) begin ref_write(int'(cur.id), int'(cur.a), cur.d); cwr = 0; end
            if (cur.kind == 3) begin cur.d = ref_read(int'(cur.id), int'(cur.a)); crd = 0; end
            if (cur.kind == 1) begin
                cur.d = ref_read(int'(cur.id), int'(cur.a));
                pend[cur.ch] = 1'b0; last_ch = cur.ch;
            end
            cpu_last = (cur.kind >= 2);
            p2 = p1; p1 = cur;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wts_sram_arbiter.md
WTS_SRAM_ARBITER -- requirements
Module: wts_sram_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 12: number of wave channels (A0..F0 = 0..5, A1..F1 = 6..11).
REQ-002 SHALL have parameter AW, default 7: wave SRAM address width.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-005 SHALL have port ch_req, input, NCH: per-channel sample fetch request, held high until acked.
REQ-006 SHALL have port ch_addr, input, NCH*AW: packed per-channel sample address; channel i occupies bits [i*AW +: AW].
REQ-007 SHALL have port ch_ack, output, NCH: one-hot grant pulse to the served channel.
REQ-008 SHALL have port fetch_valid, output, 1: read data valid for a channel fetch.
REQ-009 SHALL have port fetch_ch, output, 4: channel index of fetch_data.
REQ-010 SHALL have port fetch_data, output, 8: sample byte.
REQ-011 SHALL have port cpu_wrreq, input, 1: CPU wave write request, held until cpu_ack.
REQ-012 SHALL have port cpu_rdreq, input, 1: CPU wave read request, held until cpu_ack.
REQ-013 SHALL have port cpu_id, input, 4: target wave memory id, encoded as {bank, letter}.
REQ-014 SHALL have port cpu_a, input, AW: CPU address.
REQ-015 SHALL have port cpu_d, input, 8: CPU write data.
REQ-016 SHALL have port cpu_ack, output, 1: one-cycle grant pulse to the CPU.
REQ-017 SHALL have port cpu_q, output, 8: CPU read data.
REQ-018 SHALL have port cpu_q_en, output, 1: cpu_q valid pulse.
REQ-019 SHALL have port sram_id, output, 4: memory id to SRAM.
REQ-020 SHALL have port sram_a, output, AW: address to SRAM.
REQ-021 SHALL have port sram_d, output, 8: write data to SRAM.
REQ-022 SHALL have port sram_oe, output, 1: read strobe to SRAM.
REQ-023 SHALL have port sram_we, output, 1: write strobe to SRAM.
REQ-024 SHALL have port sram_q, input, 8: SRAM read data, valid exactly one cycle after sram_oe.

Function
REQ-025 SHALL evaluate one arbitration per cycle and issue at most one SRAM access per cycle; strobes, id, address and data SHALL be registered and asserted in the cycle after the grant.
REQ-026 SHALL give the CPU priority over channels, except that the CPU SHALL NOT win two consecutive grants while any ch_req bit is high.
REQ-027 SHALL serve channels round-robin: the search starts at the index after the last-granted channel and wraps from NCH-1 to 0.
REQ-028 SHALL give a write priority over a read when cpu_wrreq and cpu_rdreq are both high; the read SHALL remain pending.
REQ-029 SHALL map channel i to sram_id = {i>=6, i mod 6} and sram_a = ch_addr slice i.
REQ-030 SHALL pulse ch_ack[i] or cpu_ack in the grant cycle.
REQ-031 SHALL return read data from sram_q at a fixed latency of 2 cycles after the grant:
- channel grant: fetch_valid=1, fetch_ch = granted index;
- CPU read grant: cpu_q_en=1.
REQ-032 SHALL keep fetch_data and cpu_q holding their last value when not valid.
REQ-033 SHALL assert sram_oe=sram_we=0 in cycles with no grant; sram_oe and sram_we SHALL never be high together.
REQ-034 SHALL ignore channel indices >= NCH and SHALL never ack an unrequested channel.
REQ-035 SHALL sustain full throughput: with NCH requests held, every channel is acked once per NCH cycles and one grant occurs every cycle.

Reset
REQ-036 SHALL, while reset is high, drive every output to 0 (ch_ack, cpu_ack, fetch_valid, fetch_ch, fetch_data, cpu_q, cpu_q_en, sram_*).
REQ-037 SHALL reset the round-robin pointer so that channel 0 is searched first, and clear the CPU-last flag.
REQ-038 SHALL discard in-flight reads when reset is asserted mid-operation; no valid pulse for those reads SHALL appear after reset.

Structure
REQ-039 SHALL place channel-index-to-sram_id encoding constants and the NCH and AW defaults in the shared wts package.
REQ-040 SHALL contain one sub-module, wts_rr_picker: a combinational next-index search from a pointer over a request vector.

Verification
REQ-041 Reset check: after reset, ch_req=all ones -> ch_ack order 0,1,...,11,0, one per cycle; fetch_valid 2 cycles after each ack.
REQ-042 CPU starvation check: cpu_wrreq held with ch_req=0x003 -> grants cpu, ch0, cpu, ch1, cpu; sram_we only in the CPU slots.
REQ-043 Simultaneous write/read: cpu_wrreq=cpu_rdreq=1 -> write acked first, read acked next; cpu_q_en 2 cycles later with cpu_q = sram_q.
REQ-044 Channel 9 fetch: ch_req=0x200, ch_addr[9]=0x15 -> sram_id=4'b1011, sram_a=0x15, sram_oe=1; fetch_ch=9.
REQ-045 Mid-op reset: reset pulsed 1 cycle after a grant -> no fetch_valid; all outputs 0 the cycle after reset.
REQ-046 Idle check: no requests for 20 cycles -> sram_oe and sram_we stay 0 and no ack pulses occur.
